// File: rtl/divu_hilo_unit_if.sv
// divu_hilo_unit_if: execute-stage bus between the controller/datapath and
// the multi-cycle HI/LO divider.
//
// Handshake: a divide is issued by presenting a divide funct code on Signal
// together with dataA/dataB. The unit accepts it only while idle (busy==0
// and done==0); codes presented while busy or during the done cycle are
// dropped, so the master holds off until busy falls. done pulses for one
// cycle when HI/LO have just been written. dataOut is a combinational read
// of HI/LO selected by Signal.
interface divu_hilo_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [5:0]       Signal;
    logic [WIDTH-1:0] dataOut;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output dataA, dataB, Signal,
        input  dataOut, busy, done, div_zero
    );

    modport slave (
        input  dataA, dataB, Signal,
        output dataOut, busy, done, div_zero
    );
endinterface

// File: rtl/divu_hilo_unit.sv
// divu_hilo_unit: multi-cycle restoring divider writing HI (remainder) and
// LO (quotient), with MFHI/MFLO read-back on dataOut. One quotient bit per
// clock, WIDTH iterations per divide.
//
// Optional feature macro: DIV_SIGNED_EN adds the signed DIV funct code;
// operands are divided as magnitudes and the results sign-corrected when
// HI/LO are written. Without it, DIV is an unknown code and ignored.
module divu_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    divu_hilo_unit_if.slave  bus,
    output logic [1:0]       dbg_state
);

    localparam logic [5:0] FN_DIVU = 6'd27;
    localparam logic [5:0] FN_MFHI = 6'd16;
    localparam logic [5:0] FN_MFLO = 6'd18;
`ifdef DIV_SIGNED_EN
    localparam logic [5:0] FN_DIV  = 6'd26;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] q;        // dividend shifts out the top, quotient in at the bottom
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] divisor;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy_r;
    logic             done_r;
    logic             dz_r;
`ifdef DIV_SIGNED_EN
    logic             neg_q;
    logic             neg_r;
`endif

    // Issue decode and operand conditioning.
    logic             is_div;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
`ifdef DIV_SIGNED_EN
    logic             a_neg;
    logic             b_neg;
`endif

    // Decide whether Signal starts a divide and form the operands to latch.
    always_comb begin
        is_div = (bus.Signal == FN_DIVU);
        a_in   = bus.dataA;
        b_in   = bus.dataB;
`ifdef DIV_SIGNED_EN
        a_neg  = 1'b0;
        b_neg  = 1'b0;
        if (bus.Signal == FN_DIV) begin
            is_div = 1'b1;
            a_neg  = bus.dataA[WIDTH-1];
            b_neg  = bus.dataB[WIDTH-1];
            a_in   = a_neg ? (~bus.dataA + 1'b1) : bus.dataA;
            b_in   = b_neg ? (~bus.dataB + 1'b1) : bus.dataB;
        end
`endif
    end

    // One restoring step. The subtraction is WIDTH+1 bits wide: the shifted
    // remainder can exceed WIDTH bits when the divisor has its MSB set, and
    // bit WIDTH of the difference is the borrow (1 = divisor did not fit).
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] lo_fin;
    logic [WIDTH-1:0] hi_fin;
    logic             last;

    // Next quotient/remainder for this iteration and the values to commit.
    always_comb begin
        rem_sh   = {rem, q[WIDTH-1]};
        diff     = rem_sh - {1'b0, divisor};
        fits     = ~diff[WIDTH];
        q_next   = {q[WIDTH-2:0], fits};
        rem_next = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        lo_fin   = q_next;
        hi_fin   = rem_next;
`ifdef DIV_SIGNED_EN
        if (neg_q) lo_fin = ~q_next + 1'b1;
        if (neg_r) hi_fin = ~rem_next + 1'b1;
`endif
        last     = (cnt == CNT_W'(WIDTH - 1));
    end

    // Control FSM with datapath registers; HI/LO change only on the last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            q       <= '0;
            rem     <= '0;
            divisor <= '0;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dz_r    <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (is_div) begin
                        q       <= a_in;
                        divisor <= b_in;
                        rem     <= '0;
                        cnt     <= '0;
                        busy_r  <= 1'b1;
`ifdef DIV_SIGNED_EN
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
`endif
                        state   <= RUN;
                    end
                end
                RUN: begin
                    q   <= q_next;
                    rem <= rem_next;
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        hi     <= hi_fin;
                        lo     <= lo_fin;
                        dz_r   <= (divisor == '0);
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Combinational HI/LO read-back selected by the funct code.
    always_comb begin
        case (bus.Signal)
            FN_MFHI: bus.dataOut = hi;
            FN_MFLO: bus.dataOut = lo;
            default: bus.dataOut = '0;
        endcase
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.div_zero = dz_r;
    assign dbg_state    = state;

endmodule

// File: tb/tb_divu_hilo_unit.sv
// tb_divu_hilo_unit: random and directed divides against a plain-arithmetic
// HI/LO model; every dataOut read and every done pulse is scored from queues.
module tb_divu_hilo_unit;

    localparam int W = 32;
    localparam logic [5:0] FN_DIVU = 6'd27;
    localparam logic [5:0] FN_MFHI = 6'd16;
    localparam logic [5:0] FN_MFLO = 6'd18;
    localparam logic [5:0] FN_ADD  = 6'd32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    divu_hilo_unit_if #(.WIDTH(W)) bus ();
    logic [1:0] dbg_state;

    divu_hilo_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] exp_q[$];       // expected dataOut, one per driven cycle
    int           done_cyc_q[$];  // cycle at which done must be seen
    logic         dz_q[$];        // expected div_zero at that done
    logic         pend = 1'b0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_dz = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] exp_out(input logic [5:0] s);
        if (s == FN_MFHI) return m_hi;
        if (s == FN_MFLO) return m_lo;
        return '0;
    endfunction

    function automatic logic [5:0] rand_sig();
        case ($urandom_range(0, 4))
            0: return FN_MFHI;
            1: return FN_MFLO;
            2: return FN_ADD;
            3: return FN_DIVU;
            default: return 6'h3f;
        endcase
    endfunction

    function automatic logic [5:0] rand_rd();
        case ($urandom_range(0, 2))
            0: return FN_MFHI;
            1: return FN_MFLO;
            default: return FN_ADD;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [5:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.Signal = s;
        bus.dataA  = a;
        bus.dataB  = b;
        exp_q.push_back(exp_out(s));
        pend = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide; during RUN present random reads and stray DIVUs
    // (a fixed stray DIVU 8/2 on the fifth RUN cycle).
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] p_lo;
        logic [W-1:0] p_hi;
        logic         p_dz;
        int           n;
        drive(FN_DIVU, a, b);
        step();
        n    = cyc;
        p_dz = (b == '0);
        p_lo = p_dz ? '1 : a / b;
        p_hi = p_dz ? a : a % b;
        done_cyc_q.push_back(n + W);
        dz_q.push_back(p_dz);
        for (int i = 0; i < W; i++) begin
            check_bit("busy_run", bus.busy, 1'b1);
            if (i == 4) drive(FN_DIVU, 32'd8, 32'd2);
            else        drive(rand_sig(), $urandom, $urandom);
            step();
        end
        m_hi = p_hi;
        m_lo = p_lo;
        m_dz = p_dz;
        check_bit("busy_done", bus.busy, 1'b0);
        check_bit("div_zero_after", bus.div_zero, m_dz);
        drive(rand_sig(), $urandom, $urandom);   // DONE cycle: any DIVU is dropped
        step();
    endtask

    // Issue a divide and hit reset k cycles into RUN.
    task automatic run_reset(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        drive(FN_DIVU, a, b);
        step();
        done_cyc_q.push_back(cyc + W);
        dz_q.push_back(b == '0);
        for (int i = 0; i < k; i++) begin
            drive(rand_rd(), '0, '0);
            step();
        end
        reset = 1'b1;
        drive(rand_rd(), '0, '0);
        step();
        reset = 1'b0;
        done_cyc_q.delete();
        dz_q.delete();
        m_hi = '0;
        m_lo = '0;
        m_dz = 1'b0;
        check_bit("busy_reset", bus.busy, 1'b0);
        check_bit("done_reset", bus.done, 1'b0);
        check_bit("dz_reset", bus.div_zero, 1'b0);
        for (int i = 0; i < W + 8; i++) begin
            drive(rand_rd(), '0, '0);
            step();
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (pend) begin
            pend = 1'b0;
            if (exp_q.size() > 0) check("dataOut", bus.dataOut, exp_q.pop_front());
        end
        if (!reset) begin
            if (bus.done) begin
                if (done_cyc_q.size() == 0) begin
                    check_bit("done_spurious", bus.done, 1'b0);
                end else begin
                    check("done_cycle", W'(cyc), W'(done_cyc_q.pop_front()));
                    check_bit("div_zero", bus.div_zero, dz_q.pop_front());
                end
            end else if (done_cyc_q.size() > 0 && cyc > done_cyc_q[0]) begin
                check_bit("done_missing", bus.done, 1'b1);
                void'(done_cyc_q.pop_front());
                void'(dz_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        bus.Signal = '0;
        bus.dataA  = '0;
        bus.dataB  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_bit("busy_init", bus.busy, 1'b0);
        check_bit("done_init", bus.done, 1'b0);
        check_bit("dz_init", bus.div_zero, 1'b0);
        drive(FN_MFHI, '0, '0); step();
        drive(FN_MFLO, '0, '0); step();

        run_div(32'd100, 32'd7);
        drive(FN_MFLO, '0, '0); step();
        drive(FN_MFHI, '0, '0); step();
        run_div(32'd5, 32'd0);
        run_div(32'd9, 32'd3);
        run_div(32'hFFFF_FFFF, 32'd1);
        run_div(32'd100, 32'd7);
        run_div(32'd50, 32'd5);
        drive(FN_ADD, '0, '0); step();
        run_div(32'd0, 32'd13);
        run_div(32'hFFFF_FFFF, 32'h8000_0001);
        run_div(32'd7, 32'hFFFF_FFFF);
        run_reset(32'd1000, 32'd3, 10);

        for (int t = 0; t < 20; t++) begin
            a = $urandom;
            if ($urandom_range(0, 5) == 0) a = '0;
            case ($urandom_range(0, 3))
                0: b = '0;
                1: b = W'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            run_div(a, b);
            drive(rand_rd(), '0, '0); step();
        end

        repeat (4) begin
            drive(rand_rd(), '0, '0);
            step();
        end
        check("done_q_drained", W'(done_cyc_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog so a stuck run still reports.
    initial begin
        #500000;
        n_vec++;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
